// File: rtl/scrambler_gen3_ctrl.sv
// Gen3 128b/130b per-lane transmit scrambler: 23-bit Galois LFSR keystream XORed
// into 16-bit beats, with ordered-set exceptions and one registered cycle of latency.
module scrambler_gen3_ctrl #(
  parameter logic [23:0] SEED            = 24'h1DBFBC,
  parameter int          BEATS_PER_BLOCK = 8
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  input  logic        block_start,
  input  logic [1:0]  sync_header,
  input  logic        scrambler_reset,
  output logic [15:0] data_out,
  output logic        data_out_valid,
  output logic        block_start_out,
  output logic [1:0]  sync_header_out,
  output logic        hdr_err,
  output logic        frame_err
);

  localparam logic [22:0] LFSR_SEED = SEED[22:0];
  localparam logic [22:0] LFSR_TAPS = 23'h210125;
  localparam logic [2:0]  LAST_BEAT = 3'(BEATS_PER_BLOCK - 1);

  typedef enum logic [0:0] {IDLE, IN_BLOCK} state_t;
  typedef enum logic [1:0] {T_DATA, T_OS, T_SKP, T_EIEOS} blk_t;

  state_t      r_state, w_stateNext;
  blk_t        r_type, w_typeNext, w_typeDecoded, w_typeCur;
  logic [2:0]  r_beat, w_beatNext, w_beatCur;
  logic [22:0] r_lfsr, w_lfsrNext, w_lfsrAdv;
  logic [15:0] w_keystream;
  logic [15:0] w_dataNext;
  logic        w_isStart, w_framed, w_hdrBad, w_hdrErr, w_frameErr, w_accept;

  logic [15:0] r_dataOut;
  logic        r_validOut, r_startOut, r_hdrErr, r_frameErr;
  logic [1:0]  r_hdrOut;

  // Unrolled 16-step Galois advance; keystream bit is the MSB before each shift.
  always_comb begin
    w_lfsrAdv   = r_lfsr;
    w_keystream = '0;
    for (int i = 0; i < 16; i++) begin
      w_keystream[i] = w_lfsrAdv[22];
      w_lfsrAdv      = {w_lfsrAdv[21:0], 1'b0} ^ (w_lfsrAdv[22] ? LFSR_TAPS : 23'h0);
    end
  end

  // Block type decode, valid only on beat 0 of a block.
  always_comb begin
    w_typeDecoded = T_DATA;
    if (sync_header == 2'b01) begin
      case (data_in[7:0])
        8'hAA:   w_typeDecoded = T_SKP;
        8'h00:   w_typeDecoded = T_EIEOS;
        default: w_typeDecoded = T_OS;
      endcase
    end
  end

  assign w_isStart = data_valid & block_start;
  assign w_hdrBad  = (sync_header == 2'b00) | (sync_header == 2'b11);
  assign w_typeCur = w_isStart ? w_typeDecoded : r_type;
  assign w_beatCur = w_isStart ? 3'd0 : r_beat;
  assign w_framed  = w_isStart | (r_state == IN_BLOCK);
  assign w_accept  = data_valid & ~scrambler_reset;

  always_comb begin
    w_stateNext = r_state;
    w_beatNext  = r_beat;
    w_typeNext  = r_type;
    w_lfsrNext  = r_lfsr;
    w_dataNext  = data_in;
    w_hdrErr    = 1'b0;
    w_frameErr  = 1'b0;
    if (scrambler_reset) begin
      w_stateNext = IDLE;
      w_beatNext  = 3'd0;
      w_lfsrNext  = LFSR_SEED;
    end else if (data_valid) begin
      if (w_isStart) begin
        w_typeNext = w_typeDecoded;
        w_hdrErr   = w_hdrBad;
        w_frameErr = (r_state == IN_BLOCK);
      end
      // Unframed beats in IDLE fall through in clear with the LFSR held.
      if (w_framed) begin
        case (w_typeCur)
          T_DATA: begin
            w_dataNext = data_in ^ w_keystream;
            w_lfsrNext = w_lfsrAdv;
          end
          T_OS: begin
            w_dataNext = data_in ^ ((w_beatCur == 3'd0) ? {w_keystream[15:8], 8'h00} : w_keystream);
            w_lfsrNext = w_lfsrAdv;
          end
          T_SKP: begin
            w_dataNext = data_in;
          end
          T_EIEOS: begin
            w_dataNext = data_in;
            w_lfsrNext = (w_beatCur == LAST_BEAT) ? LFSR_SEED : w_lfsrAdv;
          end
          default: begin
            w_dataNext = data_in;
          end
        endcase
        if (w_beatCur == LAST_BEAT) begin
          w_stateNext = IDLE;
          w_beatNext  = 3'd0;
        end else begin
          w_stateNext = IN_BLOCK;
          w_beatNext  = w_beatCur + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_beat  <= 3'd0;
      r_type  <= T_DATA;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_state <= w_stateNext;
      r_beat  <= w_beatNext;
      r_type  <= w_typeNext;
      r_lfsr  <= w_lfsrNext;
    end
  end

  // data_out keeps its last value through idle and dropped cycles.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_dataOut  <= '0;
      r_validOut <= 1'b0;
      r_startOut <= 1'b0;
      r_hdrOut   <= 2'b00;
      r_hdrErr   <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_validOut <= w_accept;
      r_startOut <= w_accept & block_start;
      r_hdrOut   <= (w_accept & block_start) ? sync_header : 2'b00;
      r_hdrErr   <= w_hdrErr;
      r_frameErr <= w_frameErr;
      if (w_accept) begin
        r_dataOut <= w_dataNext;
      end
    end
  end

  assign data_out        = r_dataOut;
  assign data_out_valid  = r_validOut;
  assign block_start_out = r_startOut;
  assign sync_header_out = r_hdrOut;
  assign hdr_err         = r_hdrErr;
  assign frame_err       = r_frameErr;

endmodule

// File: tb/tb_scrambler_gen3_ctrl.sv
// Self-checking bench for scrambler_gen3_ctrl: directed block sequences plus random
// traffic, all checked against a block-level reference model of the scrambler.
module tb_scrambler_gen3_ctrl;

  localparam int SEED = 32'h001DBFBC;
  // G(X) including the X^23 term: multiply-by-X then reduce.
  localparam int POLY = 32'h00A10125;
  localparam int T_DATA = 0, T_OS = 1, T_SKP = 2, T_EIEOS = 3;

  logic        pclk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;
  logic        block_start;
  logic [1:0]  sync_header;
  logic        scrambler_reset;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        block_start_out;
  logic [1:0]  sync_header_out;
  logic        hdr_err;
  logic        frame_err;

  int compareCount  = 0;
  int mismatchCount = 0;

  int          mLfsr;
  bit          mInBlock;
  int          mBeat;
  int          mType;
  logic [15:0] mDataOut;

  logic [15:0] blockOut [8];
  logic [15:0] refOut [8];

  scrambler_gen3_ctrl dut (
    .pclk            (pclk),
    .reset           (reset),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .block_start     (block_start),
    .sync_header     (sync_header),
    .scrambler_reset (scrambler_reset),
    .data_out        (data_out),
    .data_out_valid  (data_out_valid),
    .block_start_out (block_start_out),
    .sync_header_out (sync_header_out),
    .hdr_err         (hdr_err),
    .frame_err       (frame_err)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] modelKeystream(input int s);
    logic [15:0] k;
    for (int i = 0; i < 16; i++) begin
      k[i] = s[22];
      s = s << 1;
      if (s[23]) s = s ^ POLY;
    end
    return k;
  endfunction

  function automatic int modelAdvance(input int s);
    for (int i = 0; i < 16; i++) begin
      s = s << 1;
      if (s[23]) s = s ^ POLY;
    end
    return s;
  endfunction

  function automatic int decodeType(input logic [1:0] h, input logic [7:0] sym0);
    if (h != 2'b01) return T_DATA;
    if (sym0 == 8'hAA) return T_SKP;
    if (sym0 == 8'h00) return T_EIEOS;
    return T_OS;
  endfunction

  task automatic modelReset();
    mLfsr    = SEED;
    mInBlock = 0;
    mBeat    = 0;
    mType    = T_DATA;
    mDataOut = 16'h0000;
  endtask

  // Drive one cycle, predict the registered response, then check it after the edge.
  task automatic applyStimulus(input string tag, input logic [15:0] d, input logic v,
                               input logic bs, input logic [1:0] h, input logic sr);
    logic        eValid, eStart, eHdrErr, eFrameErr;
    logic [1:0]  eHdr;
    logic [15:0] ks;
    eValid = 0; eStart = 0; eHdr = 2'b00; eHdrErr = 0; eFrameErr = 0;
    data_in = d; data_valid = v; block_start = bs; sync_header = h; scrambler_reset = sr;
    if (sr) begin
      mLfsr = SEED; mInBlock = 0; mBeat = 0;
    end else if (v) begin
      eValid = 1;
      if (bs) begin
        eStart    = 1;
        eHdr      = h;
        eHdrErr   = (h == 2'b00) || (h == 2'b11);
        eFrameErr = mInBlock;
        mType     = decodeType(h, d[7:0]);
        mBeat     = 0;
        mInBlock  = 1;
      end
      if (!mInBlock) begin
        mDataOut = d;
      end else begin
        ks = modelKeystream(mLfsr);
        case (mType)
          T_DATA:  begin mDataOut = d ^ ks; mLfsr = modelAdvance(mLfsr); end
          T_OS:    begin mDataOut = d ^ (mBeat == 0 ? (ks & 16'hFF00) : ks); mLfsr = modelAdvance(mLfsr); end
          T_SKP:   mDataOut = d;
          default: begin mDataOut = d; mLfsr = (mBeat == 7) ? SEED : modelAdvance(mLfsr); end
        endcase
        mBeat++;
        if (mBeat == 8) begin
          mInBlock = 0;
          mBeat    = 0;
        end
      end
    end
    @(posedge pclk);
    #1;
    checkOutput({tag, " data_out"},        32'(data_out),        32'(mDataOut));
    checkOutput({tag, " data_out_valid"},  32'(data_out_valid),  32'(eValid));
    checkOutput({tag, " block_start_out"}, 32'(block_start_out), 32'(eStart));
    checkOutput({tag, " sync_header_out"}, 32'(sync_header_out), 32'(eHdr));
    checkOutput({tag, " hdr_err"},         32'(hdr_err),         32'(eHdrErr));
    checkOutput({tag, " frame_err"},       32'(frame_err),       32'(eFrameErr));
  endtask

  task automatic sendBlock(input string tag, input logic [1:0] h, input logic [15:0] beat0,
                           input logic [15:0] rest, input int gapAt);
    for (int b = 0; b < 8; b++) begin
      if (b == gapAt && b > 0) begin
        repeat (3) applyStimulus({tag, " gap"}, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0);
      end
      applyStimulus(tag, (b == 0) ? beat0 : rest, 1'b1, (b == 0), h, 1'b0);
      blockOut[b] = data_out;
    end
  endtask

  task automatic checkAgainstRef(input string tag);
    for (int b = 0; b < 8; b++) begin
      checkOutput($sformatf("%s beat%0d", tag, b), 32'(blockOut[b]), 32'(refOut[b]));
    end
  endtask

  initial begin
    int ksState;
    reset = 1'b1; data_in = '0; data_valid = 0; block_start = 0; sync_header = 0; scrambler_reset = 0;
    modelReset();
    repeat (2) @(posedge pclk);
    #1;
    checkOutput("reset data_out",       32'(data_out),        32'h0);
    checkOutput("reset valid",          32'(data_out_valid),  32'h0);
    checkOutput("reset block_start",    32'(block_start_out), 32'h0);
    checkOutput("reset sync_header",    32'(sync_header_out), 32'h0);
    checkOutput("reset hdr_err",        32'(hdr_err),         32'h0);
    checkOutput("reset frame_err",      32'(frame_err),       32'h0);
    reset = 1'b0;

    sendBlock("data1", 2'b10, 16'h0000, 16'h0000, 0);
    ksState = SEED;
    for (int b = 0; b < 8; b++) begin
      refOut[b] = blockOut[b];
      checkOutput($sformatf("seed keystream beat%0d", b), 32'(blockOut[b]), 32'(modelKeystream(ksState)));
      ksState = modelAdvance(ksState);
    end

    sendBlock("skp", 2'b01, 16'hAAAA, 16'hAAAA, 0);
    for (int b = 0; b < 8; b++) checkOutput($sformatf("skp clear beat%0d", b), 32'(blockOut[b]), 32'h0000AAAA);
    sendBlock("data2", 2'b10, 16'h0000, 16'h0000, 0);
    checkOutput("data2 continues keystream", 32'(blockOut[0]), 32'(modelKeystream(ksState)));

    sendBlock("eieos", 2'b01, 16'hFF00, 16'hFF00, 0);
    for (int b = 0; b < 8; b++) checkOutput($sformatf("eieos clear beat%0d", b), 32'(blockOut[b]), 32'h0000FF00);
    sendBlock("post-eieos", 2'b10, 16'h0000, 16'h0000, 0);
    checkAgainstRef("post-eieos reseed");

    sendBlock("ts1", 2'b01, 16'h001E, 16'h0000, 0);
    checkOutput("ts1 symbol0 clear", 32'(blockOut[0][7:0]), 32'h1E);

    sendBlock("gapped", 2'b10, 16'h1234, 16'h5678, 3);

    applyStimulus("frame a", 16'h0000, 1'b1, 1'b1, 2'b10, 1'b0);
    for (int b = 1; b < 4; b++) applyStimulus("frame a", 16'h0000, 1'b1, 1'b0, 2'b10, 1'b0);
    applyStimulus("frame restart", 16'h0000, 1'b1, 1'b1, 2'b10, 1'b0);
    checkOutput("frame_err pulse", 32'(frame_err), 32'h1);
    for (int b = 1; b < 8; b++) applyStimulus("frame b", 16'h0000, 1'b1, 1'b0, 2'b10, 1'b0);

    sendBlock("hdr11", 2'b11, 16'h0000, 16'h0000, 0);

    applyStimulus("srst a", 16'h0000, 1'b1, 1'b1, 2'b10, 1'b0);
    applyStimulus("srst a", 16'h0000, 1'b1, 1'b0, 2'b10, 1'b0);
    applyStimulus("srst drop", 16'h0000, 1'b1, 1'b0, 2'b10, 1'b1);
    sendBlock("post-srst", 2'b10, 16'h0000, 16'h0000, 0);
    checkAgainstRef("post-srst seed");

    applyStimulus("areset a", 16'h0000, 1'b1, 1'b1, 2'b10, 1'b0);
    applyStimulus("areset a", 16'h0000, 1'b1, 1'b0, 2'b10, 1'b0);
    data_valid = 1'b0; block_start = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("areset data_out", 32'(data_out),       32'h0);
    checkOutput("areset valid",    32'(data_out_valid), 32'h0);
    @(posedge pclk);
    #1;
    reset = 1'b0;
    modelReset();
    sendBlock("post-areset", 2'b10, 16'h0000, 16'h0000, 0);
    checkAgainstRef("post-areset seed");

    for (int n = 0; n < 400; n++) begin
      logic        v, bs, sr;
      logic [1:0]  h;
      logic [15:0] d;
      v  = ($urandom_range(0, 9) < 8);
      bs = mInBlock ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0, 1, 2: h = 2'b10;
        3, 4:    h = 2'b01;
        default: h = 2'($urandom_range(0, 3));
      endcase
      d = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       d[7:0] = 8'hAA;
        1:       d[7:0] = 8'h00;
        2:       d[7:0] = 8'h1E;
        default: d[7:0] = d[7:0];
      endcase
      sr = ($urandom_range(0, 49) == 0);
      applyStimulus("random", d, v, bs, h, sr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
